// File: rtl/tron_fetch_unit_if.sv
// ============================================================================
// Module      : tron_fetch_unit_if
// Description : Core-side instruction handshake and instruction-memory read
//               bus of the TRON fetch unit, bundled as one interface.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface tron_fetch_unit_if;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        instr_ready;
    logic [15:0] instruction;
    logic [15:0] instr_addr;
    logic        instr_valid;
    logic        mem_rd;
    logic [15:0] mem_addr;
    logic [15:0] mem_rdata;
    logic        mem_ack;

    // master: the fetch unit itself; slave: core plus instruction memory
    modport master (
        input  redirect, redirect_pc, instr_ready, mem_rdata, mem_ack,
        output instruction, instr_addr, instr_valid, mem_rd, mem_addr
    );

    modport slave (
        output redirect, redirect_pc, instr_ready, mem_rdata, mem_ack,
        input  instruction, instr_addr, instr_valid, mem_rd, mem_addr
    );
endinterface

`default_nettype wire

// File: rtl/tron_fetch_unit.sv
// ============================================================================
// Module      : tron_fetch_unit
// Description : Sequential instruction prefetcher with a DEPTH-entry FIFO,
//               one outstanding memory read and redirect handling.
//               Optional macro FETCH_BYPASS_EN: forward a returning word
//               straight to the core when the FIFO is empty.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tron_fetch_unit #(
    parameter int          DEPTH    = 4,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  wire logic          clk,
    input  wire logic          reset,
    tron_fetch_unit_if.master  bus
);

    localparam int                 c_PTR_W   = $clog2(DEPTH);
    localparam logic [c_PTR_W:0]   c_DEPTH   = (c_PTR_W + 1)'(DEPTH);
    localparam logic [c_PTR_W:0]   c_CNT_ONE = {{c_PTR_W{1'b0}}, 1'b1};
    localparam logic [c_PTR_W-1:0] c_PTR_ONE = {{(c_PTR_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [15:0]        r_fetch_pc;
    logic [15:0]        w_fetch_pc_nxt;
    logic [15:0]        r_target_pc;
    logic [15:0]        w_target_pc_nxt;
    logic [c_PTR_W:0]   r_count;
    logic [c_PTR_W:0]   w_count_nxt;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [15:0]        r_fifo_addr [DEPTH];
    logic [15:0]        r_fifo_data [DEPTH];

    logic w_empty;
    logic w_bypass;
    logic w_byp_take;
    logic w_push;
    logic w_pop;

    assign w_empty = (r_count == '0);

`ifdef FETCH_BYPASS_EN
    assign w_bypass = w_empty && (r_state == READ) && bus.mem_ack && !bus.redirect;
`else
    assign w_bypass = 1'b0;
`endif

    // A bypassed word that the core takes immediately never enters the FIFO
    assign w_byp_take = w_bypass && bus.instr_ready;
    assign w_push     = (r_state == READ) && bus.mem_ack && !bus.redirect && !w_byp_take;
    assign w_pop      = !w_empty && bus.instr_ready && !bus.redirect;

    always_comb begin
        w_count_nxt = r_count;
        if (bus.redirect) begin
            w_count_nxt = '0;
        end else if (w_push && !w_pop) begin
            w_count_nxt = r_count + c_CNT_ONE;
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - c_CNT_ONE;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_fetch_pc_nxt  = r_fetch_pc;
        w_target_pc_nxt = r_target_pc;
        unique case (r_state)
            IDLE: begin
                if (bus.redirect) begin
                    w_fetch_pc_nxt = bus.redirect_pc;
                end else if (r_count < c_DEPTH) begin
                    w_state_nxt = READ;
                end
            end
            READ: begin
                if (bus.mem_ack) begin
                    if (bus.redirect) begin
                        w_fetch_pc_nxt = bus.redirect_pc;
                    end else begin
                        w_fetch_pc_nxt = r_fetch_pc + 16'd1;
                        w_state_nxt    = (w_count_nxt < c_DEPTH) ? READ : IDLE;
                    end
                end else if (bus.redirect) begin
                    // The old read stays on the bus until memory completes it
                    w_target_pc_nxt = bus.redirect_pc;
                    w_state_nxt     = DROP;
                end
            end
            DROP: begin
                if (bus.redirect) begin
                    w_target_pc_nxt = bus.redirect_pc;
                end
                if (bus.mem_ack) begin
                    w_fetch_pc_nxt = bus.redirect ? bus.redirect_pc : r_target_pc;
                    w_state_nxt    = READ;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_fetch_pc  <= RESET_PC;
            r_target_pc <= RESET_PC;
            r_count     <= '0;
            r_rd_ptr    <= '0;
            r_wr_ptr    <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_fetch_pc  <= w_fetch_pc_nxt;
            r_target_pc <= w_target_pc_nxt;
            r_count     <= w_count_nxt;
            if (bus.redirect) begin
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_addr[r_wr_ptr] <= r_fetch_pc;
            r_fifo_data[r_wr_ptr] <= bus.mem_rdata;
        end
    end

    assign bus.mem_rd      = (r_state != IDLE);
    assign bus.mem_addr    = r_fetch_pc;
    assign bus.instr_valid = !w_empty || w_bypass;
    assign bus.instruction = w_bypass ? bus.mem_rdata :
                             (!w_empty ? r_fifo_data[r_rd_ptr] : 16'h0000);
    assign bus.instr_addr  = w_bypass ? r_fetch_pc :
                             (!w_empty ? r_fifo_addr[r_rd_ptr] : 16'h0000);

endmodule

`default_nettype wire

// File: tb/tb_tron_fetch_unit.sv
// ============================================================================
// Module      : tb_tron_fetch_unit
// Description : Self-checking bench for tron_fetch_unit: directed scenarios
//               plus randomized redirect/ready/latency traffic against an
//               address-stream reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_tron_fetch_unit;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    tron_fetch_unit_if bus ();
    tron_fetch_unit_if bus2 ();

    tron_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(16'h0000)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    tron_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(16'hFFFE)) u_dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Memory contents as a function of the word address
    function automatic logic [15:0] memf(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h3C5A;
    endfunction

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    // Instruction memory model: fixed or random latency, one read at a time
    int          mem_dly      = 1;
    logic        mem_const_en = 1'b0;
    logic [15:0] mem_const    = 16'h0000;
    int          ack_count    = 0;
    logic [15:0] ack_addr [256];
    logic [15:0] pend_addr;

    initial begin : p_mem
        int wait_left;
        bit new_rd;
        wait_left     = 0;
        new_rd        = 1'b1;
        pend_addr     = 16'h0000;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 16'h0000;
        forever begin
            @(negedge clk);
            bus.mem_ack   = 1'b0;
            bus.mem_rdata = 16'h0000;
            if (reset || !bus.mem_rd) begin
                new_rd = 1'b1;
            end else begin
                if (new_rd) begin
                    wait_left = (mem_dly < 0) ? int'($urandom_range(0, 3)) : mem_dly;
                    new_rd    = 1'b0;
                    pend_addr = bus.mem_addr;
                end else begin
                    check_val("mem_addr_hold", 32'(bus.mem_addr), 32'(pend_addr));
                end
                if (wait_left == 0) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = mem_const_en ? mem_const : memf(bus.mem_addr);
                    ack_addr[ack_count % 256] = bus.mem_addr;
                    ack_count++;
                    new_rd = 1'b1;
                end else begin
                    wait_left--;
                end
            end
        end
    end

    // Second instance: zero-wait memory, always ready, records first reads
    int          n2 = 0;
    logic [15:0] a2 [3];

    initial begin : p_mem2
        bus2.redirect    = 1'b0;
        bus2.redirect_pc = 16'h0000;
        bus2.instr_ready = 1'b1;
        bus2.mem_ack     = 1'b0;
        bus2.mem_rdata   = 16'h1234;
        forever begin
            @(negedge clk);
            bus2.mem_ack = bus2.mem_rd && !reset;
            if (bus2.mem_ack && n2 < 3) begin
                a2[n2] = bus2.mem_addr;
                n2++;
            end
        end
    end

    initial begin : p_watchdog
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : p_main
        int          k;
        int          base;
        int          pops;
        bit          found;
        bit          chk_flush;
        logic [15:0] exp_next;

        reset           = 1'b1;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 16'h0000;
        bus.instr_ready = 1'b0;
        tick();
        tick();

        check_val("rst_valid",    32'(bus.instr_valid), 32'(0));
        check_val("rst_instr",    32'(bus.instruction), 32'(0));
        check_val("rst_iaddr",    32'(bus.instr_addr),  32'(0));
        check_val("rst_mem_rd",   32'(bus.mem_rd),      32'(0));
        check_val("rst_mem_addr", 32'(bus.mem_addr),    32'(0));

        // In-order delivery, one-cycle memory, constant data
        mem_dly         = 1;
        mem_const_en    = 1'b1;
        mem_const       = 16'h5152;
        bus.instr_ready = 1'b1;
        reset           = 1'b0;
        tick();
        check_val("first_mem_rd",   32'(bus.mem_rd),   32'(1));
        check_val("first_mem_addr", 32'(bus.mem_addr), 32'(0));
        k = 0;
        for (int c = 0; c < 40 && k < 4; c++) begin
            tick();
            if (bus.instr_valid) begin
                check_val("seq_addr",  32'(bus.instr_addr),  32'(k));
                check_val("seq_instr", 32'(bus.instruction), 32'(16'h5152));
                k++;
            end
        end
        check_val("seq_count", 32'(k), 32'(4));

        check_val("wrap_reads", 32'(n2), 32'(3));
        check_val("wrap_addr0", 32'(a2[0]), 32'(16'hFFFE));
        check_val("wrap_addr1", 32'(a2[1]), 32'(16'hFFFF));
        check_val("wrap_addr2", 32'(a2[2]), 32'(16'h0000));

        // FIFO fills with the core stalled, then one pop allows one refill
        reset           = 1'b1;
        bus.instr_ready = 1'b0;
        mem_const_en    = 1'b0;
        mem_dly         = 0;
        tick();
        tick();
        base  = ack_count;
        reset = 1'b0;
        repeat (20) tick();
        check_val("full_reads", 32'(ack_count - base), 32'(DEPTH));
        for (int i = 0; i < DEPTH; i++) begin
            check_val("full_addr", 32'(ack_addr[(base + i) % 256]), 32'(i));
        end
        check_val("full_mem_rd", 32'(bus.mem_rd),      32'(0));
        check_val("full_valid",  32'(bus.instr_valid), 32'(1));
        check_val("full_head",   32'(bus.instr_addr),  32'(0));
        check_val("full_data",   32'(bus.instruction), 32'(memf(16'h0000)));
        bus.instr_ready = 1'b1;
        tick();
        bus.instr_ready = 1'b0;
        repeat (10) tick();
        check_val("refill_reads", 32'(ack_count - base), 32'(DEPTH + 1));
        check_val("refill_addr",  32'(ack_addr[(base + DEPTH) % 256]), 32'(DEPTH));
        check_val("refill_mem_rd", 32'(bus.mem_rd),    32'(0));
        check_val("refill_head",  32'(bus.instr_addr), 32'(1));

        // Redirect while the read of word 2 is outstanding
        reset   = 1'b1;
        mem_dly = 3;
        tick();
        tick();
        reset = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            tick();
            if (bus.mem_rd && bus.mem_addr == 16'h0002) found = 1'b1;
        end
        check_val("redir_found", 32'(found), 32'(1));
        bus.redirect    = 1'b1;
        bus.redirect_pc = 16'h0100;
        tick();
        bus.redirect = 1'b0;
        check_val("redir_flush", 32'(bus.instr_valid), 32'(0));
        check_val("redir_hold_rd",   32'(bus.mem_rd),   32'(1));
        check_val("redir_hold_addr", 32'(bus.mem_addr), 32'(2));
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            tick();
            if (bus.mem_rd && bus.mem_addr == 16'h0100) found = 1'b1;
        end
        check_val("redir_new_addr", 32'(found), 32'(1));
        check_val("redir_dropped",  32'(bus.instr_valid), 32'(0));
        bus.instr_ready = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            tick();
            if (bus.instr_valid) found = 1'b1;
        end
        check_val("redir_valid", 32'(found), 32'(1));
        check_val("redir_iaddr", 32'(bus.instr_addr),  32'(16'h0100));
        check_val("redir_instr", 32'(bus.instruction), 32'(memf(16'h0100)));

        // First-word latency with an empty FIFO
        reset           = 1'b1;
        bus.instr_ready = 1'b1;
        mem_dly         = 2;
        mem_const_en    = 1'b1;
        mem_const       = 16'hF101;
        tick();
        tick();
        base  = ack_count;
        reset = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            tick();
            if (ack_count - base >= 1) found = 1'b1;
        end
        check_val("lat_ack", 32'(found), 32'(1));
`ifdef FETCH_BYPASS_EN
        check_val("lat_valid_same", 32'(bus.instr_valid), 32'(1));
        check_val("lat_instr_same", 32'(bus.instruction), 32'(16'hF101));
        check_val("lat_iaddr_same", 32'(bus.instr_addr),  32'(0));
        tick();
        check_val("lat_consumed", 32'(bus.instr_valid), 32'(0));
`else
        check_val("lat_valid_same", 32'(bus.instr_valid), 32'(0));
        tick();
        check_val("lat_valid_next", 32'(bus.instr_valid), 32'(1));
        check_val("lat_instr_next", 32'(bus.instruction), 32'(16'hF101));
        check_val("lat_iaddr_next", 32'(bus.instr_addr),  32'(0));
`endif

        // Randomized traffic against the expected address stream
        reset           = 1'b1;
        bus.instr_ready = 1'b0;
        tick();
        mem_dly      = -1;
        mem_const_en = 1'b0;
        reset        = 1'b0;
        exp_next     = 16'h0000;
        chk_flush    = 1'b0;
        pops         = 0;
        for (int c = 0; c < 3000; c++) begin
            tick();
            reset           = ($urandom_range(0, 999) < 3);
            bus.redirect    = !reset && ($urandom_range(0, 15) == 0);
            bus.redirect_pc = ($urandom_range(0, 3) == 0) ? 16'hFFFD : 16'($urandom);
            bus.instr_ready = ($urandom_range(0, 9) < 6);
            #1;
`ifndef FETCH_BYPASS_EN
            if (chk_flush) check_val("rnd_flush", 32'(bus.instr_valid), 32'(0));
`endif
            if (!bus.instr_valid) begin
                check_val("rnd_idle_instr", 32'(bus.instruction), 32'(0));
                check_val("rnd_idle_iaddr", 32'(bus.instr_addr),  32'(0));
            end else if (bus.instr_ready && !bus.redirect && !reset) begin
                check_val("rnd_pop_addr", 32'(bus.instr_addr),  32'(exp_next));
                check_val("rnd_pop_data", 32'(bus.instruction), 32'(memf(bus.instr_addr)));
                exp_next = exp_next + 16'd1;
                pops++;
            end
            chk_flush = bus.redirect || reset;
            if (reset) begin
                exp_next = 16'h0000;
            end else if (bus.redirect) begin
                exp_next = bus.redirect_pc;
            end
        end
        reset        = 1'b0;
        bus.redirect = 1'b0;
        check_val("rnd_progress", 32'(pops > 200), 32'(1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/tron_fetch_unit.md
TRON_FETCH_UNIT -- requirements
Module: tron_fetch_unit

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning prefetch FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter RESET_PC, default 16'h0000, meaning first fetch address after reset.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port redirect  input  1  core request to restart fetch at redirect_pc.
REQ-006 SHALL have port redirect_pc  input  16  new fetch word address.
REQ-007 SHALL have port instr_ready  input  1  core accepts the presented instruction.
REQ-008 SHALL have port instruction  output  16  instruction word to the core.
REQ-009 SHALL have port instr_addr  output  16  word address of the presented instruction.
REQ-010 SHALL have port instr_valid  output  1  instruction/instr_addr are valid.
REQ-011 SHALL have port mem_rd  output  1  instruction-memory read request.
REQ-012 SHALL have port mem_addr  output  16  instruction-memory read address.
REQ-013 SHALL have port mem_rdata  input  16  read data, valid when mem_ack is high.
REQ-014 SHALL have port mem_ack  input  1  read completion, may arrive 0..N cycles after mem_rd rises.

Function
REQ-015 SHALL fetch sequentially: fetch_pc increments by 1 (mod 2^16, 16'hFFFF wraps to 16'h0000) after each accepted read.
REQ-016 SHALL keep at most one read outstanding; mem_rd and mem_addr held stable from assertion until the mem_ack cycle.
REQ-017 SHALL use FSM states IDLE, READ, DROP.
REQ-018 IDLE -> READ when FIFO count < DEPTH and no redirect; mem_rd asserted in READ.
REQ-019 READ with mem_ack -> push {mem_addr, mem_rdata} into FIFO; go READ (next address) if count after update < DEPTH, else IDLE.
REQ-020 READ with redirect and no mem_ack -> DROP; mem_rd/mem_addr remain on the old read; target pc = redirect_pc.
REQ-021 DROP with mem_ack -> discard data, go READ at target pc; redirect in DROP updates target pc, stays DROP.
REQ-022 Redirect in the same cycle as mem_ack (READ) SHALL discard that data and go READ at redirect_pc.
REQ-023 Redirect SHALL empty the FIFO at the next edge; a simultaneous instr_ready pop is ignored.
REQ-024 Pop SHALL occur on clk edge when instr_valid and instr_ready are both high; instr_ready with instr_valid low has no effect.
REQ-025 Simultaneous push and pop SHALL leave count unchanged; count never exceeds DEPTH nor underflows.
REQ-026 instr_valid SHALL equal (count != 0) except as in REQ-031; instruction and instr_addr SHALL read 16'h0000 when instr_valid is low.
REQ-027 Latency without bypass: mem_ack in cycle N -> instr_valid high in cycle N+1 if FIFO was empty.

Reset
REQ-028 On reset: state IDLE, FIFO empty, fetch_pc = RESET_PC, instr_valid 0, instruction 16'h0000, instr_addr 16'h0000, mem_rd 0, mem_addr RESET_PC.
REQ-029 First mem_rd SHALL assert in the first cycle after reset deasserts (IDLE -> READ at first edge).
REQ-030 Reset mid-read SHALL drop the outstanding read; a mem_ack arriving after reset in IDLE is ignored.

Configuration
REQ-031 With FETCH_BYPASS_EN defined: when FIFO empty, state READ, mem_ack high, no redirect, instr_valid/instruction/instr_addr SHALL follow mem_ack/mem_rdata/mem_addr combinationally in the same cycle; if instr_ready also high the word is consumed and not pushed.
REQ-032 Without FETCH_BYPASS_EN: no combinational path from mem_* inputs to instr_* outputs; REQ-027 latency applies.

Verification
REQ-033 Reset release, mem_ack 1 cycle after each mem_rd, instr_ready=1, mem_rdata=16'h5152 -> first instr_valid with instr_addr 16'h0000, instruction 16'h5152; addresses 0,1,2,3 in order.
REQ-034 instr_ready=0, zero-wait memory -> exactly 4 reads (addr 0..3), FSM in IDLE, mem_rd 0; one pop -> one more read at addr 4.
REQ-035 Redirect to 16'h0100 while read of 16'h0002 pending (ack delayed 3 cycles) -> old data discarded, FIFO empty, next mem_addr 16'h0100, first presented instr_addr 16'h0100.
REQ-036 RESET_PC=16'hFFFE, 3 reads -> mem_addr sequence FFFE, FFFF, 0000.
REQ-037 Bypass build, FIFO empty, mem_ack with mem_rdata 16'hF101, instr_ready=1 -> instr_valid same cycle, count stays 0; non-bypass build -> valid next cycle.
